// File: rtl/bpred_pkg.sv
// Shared helpers for the fetch-stage branch predictor: counter encodings,
// saturating counter arithmetic and PC index/tag extraction.
package bpred_pkg;

    localparam int unsigned MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    // Weakly-taken encoding: only the MSB set
    function automatic word_t cnt_weak_t(input int unsigned w);
        return word_t'(1) << (w - 1);
    endfunction

    function automatic word_t cnt_weak_nt(input int unsigned w);
        return cnt_weak_t(w) - word_t'(1);
    endfunction

    function automatic word_t cnt_max(input int unsigned w);
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    function automatic word_t cnt_inc(input word_t c, input int unsigned w);
        return (c >= cnt_max(w)) ? cnt_max(w) : c + word_t'(1);
    endfunction

    function automatic word_t cnt_dec(input word_t c);
        return (c == word_t'(0)) ? c : c - word_t'(1);
    endfunction

    // Word-aligned index: pc[idx_w+1:2]
    function automatic word_t pc_idx(input word_t pc, input int unsigned idx_w);
        return (pc >> 2) & ((word_t'(1) << idx_w) - word_t'(1));
    endfunction

    function automatic word_t pc_tag(input word_t pc, input int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/bpred_fetch_unit_if.sv
// Fetch-unit bus: stall/redirect and branch resolution from EX in,
// fetch PC, prediction and perf counters out.
interface bpred_fetch_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned PERF_W = 32
);
    logic              stall_i;
    logic              redirect_i;
    logic [XLEN-1:0]   redirect_pc_i;
    logic              upd_valid_i;
    logic [XLEN-1:0]   upd_pc_i;
    logic              upd_taken_i;
    logic [XLEN-1:0]   upd_target_i;
    logic [XLEN-1:0]   pc_o;
    logic              pred_taken_o;
    logic [XLEN-1:0]   pred_target_o;
    logic [PERF_W-1:0] hit_cnt_o;
    logic [PERF_W-1:0] mispred_cnt_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i,
        output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  pc_o, pred_taken_o, pred_target_o, hit_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i,
        input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output pc_o, pred_taken_o, pred_target_o, hit_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer: combinational lookup port and a
// read-modify-write update port driven by EX resolution.
module btb_array
    import bpred_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  rd_pc,
    output logic             rd_hit_c,
    output logic [CNT_W-1:0] rd_cnt_c,
    output logic [XLEN-1:0]  rd_target_c,
    input  logic             wr_en,
    input  logic [XLEN-1:0]  wr_pc,
    input  logic             wr_taken,
    input  logic [XLEN-1:0]  wr_target
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             wr_hit_c;

    assign rd_idx = IDX_W'(pc_idx(word_t'(rd_pc), IDX_W));
    assign rd_tag = TAG_W'(pc_tag(word_t'(rd_pc), IDX_W));
    assign wr_idx = IDX_W'(pc_idx(word_t'(wr_pc), IDX_W));
    assign wr_tag = TAG_W'(pc_tag(word_t'(wr_pc), IDX_W));

    assign rd_hit_c    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_cnt_c    = cnt_q[rd_idx];
    assign rd_target_c = target_q[rd_idx];
    assign wr_hit_c    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Hit trains the counter; a taken miss evicts whatever lives at the index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_W'(cnt_weak_nt(CNT_W));
            end
        end else if (wr_en) begin
            if (wr_hit_c) begin
                if (wr_taken) begin
                    cnt_q[wr_idx]    <= CNT_W'(cnt_inc(word_t'(cnt_q[wr_idx]), CNT_W));
                    target_q[wr_idx] <= wr_target;
                end else begin
                    cnt_q[wr_idx] <= CNT_W'(cnt_dec(word_t'(cnt_q[wr_idx])));
                end
            end else if (wr_taken) begin
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= wr_target;
                cnt_q[wr_idx]    <= CNT_W'(cnt_weak_t(CNT_W));
            end
        end
    end

endmodule

// File: rtl/bpred_fetch_unit.sv
// Fetch PC register with same-cycle BTB prediction, EX redirect and
// saturating hit/mispredict performance counters.
module bpred_fetch_unit
    import bpred_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ENTRIES  = 16,
    parameter int unsigned     CNT_W    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PERF_W   = 32
) (
    input logic               clk,
    input logic               rst_n,
    bpred_fetch_unit_if.slave bus
);
    logic [XLEN-1:0]   pc_q;
    logic [PERF_W-1:0] hit_q, mispred_q;
    logic              hit_c;
    logic [CNT_W-1:0]  cnt_c;
    logic [XLEN-1:0]   btb_target_c;
    logic              pred_taken_c;
    logic [XLEN-1:0]   pred_target_c;

    btb_array #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_pc       (pc_q),
        .rd_hit_c    (hit_c),
        .rd_cnt_c    (cnt_c),
        .rd_target_c (btb_target_c),
        .wr_en       (bus.upd_valid_i),
        .wr_pc       (bus.upd_pc_i),
        .wr_taken    (bus.upd_taken_i),
        .wr_target   (bus.upd_target_i)
    );

    assign pred_taken_c  = hit_c && cnt_c[CNT_W-1];
    assign pred_target_c = pred_taken_c ? btb_target_c : pc_q + XLEN'(4);

    assign bus.pc_o          = pc_q;
    assign bus.pred_taken_o  = pred_taken_c;
    assign bus.pred_target_o = pred_target_c;
    assign bus.hit_cnt_o     = hit_q;
    assign bus.mispred_cnt_o = mispred_q;

    // Redirect wins over stall so a frozen front end still takes the fix-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (bus.redirect_i) begin
            pc_q <= bus.redirect_pc_i;
        end else if (!bus.stall_i) begin
            pc_q <= pred_target_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q     <= '0;
            mispred_q <= '0;
        end else begin
            if (hit_c && !bus.stall_i && !bus.redirect_i && (hit_q != '1)) begin
                hit_q <= hit_q + PERF_W'(1);
            end
            if (bus.redirect_i && (mispred_q != '1)) begin
                mispred_q <= mispred_q + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bpred_fetch_unit.sv
// Bench for bpred_fetch_unit: directed vector table, stall/redirect and
// async-reset sequences, then random traffic against a behavioural model.
module tb_bpred_fetch_unit;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned PERF_W  = 32;
    localparam int unsigned NVEC    = 22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bpred_fetch_unit_if #(.XLEN(XLEN), .PERF_W(PERF_W)) bus ();

    bpred_fetch_unit #(
        .XLEN     (XLEN),
        .ENTRIES  (ENTRIES),
        .CNT_W    (CNT_W),
        .RESET_PC (32'h0),
        .PERF_W   (PERF_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: plain arrays indexed by word address modulo ENTRIES
    bit          mv   [ENTRIES];
    logic [31:0] mtag [ENTRIES];
    logic [31:0] mtgt [ENTRIES];
    int          mcnt [ENTRIES];
    logic [31:0] mpc;
    longint      mhit, mmis;

    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int CHALF = 1 << (CNT_W - 1);

    function automatic void model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            mv[i]   = 1'b0;
            mcnt[i] = CHALF - 1;
        end
        mpc  = 32'h0;
        mhit = 0;
        mmis = 0;
    endfunction

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'(ENTRIES));
    endfunction

    function automatic logic [31:0] tagof(input logic [31:0] pc);
        return pc / 32'(4 * ENTRIES);
    endfunction

    function automatic void model_predict(output bit hit, output bit tk, output logic [31:0] tgt);
        int i;
        i   = slot(mpc);
        hit = mv[i] && (mtag[i] == tagof(mpc));
        tk  = hit && (mcnt[i] >= CHALF);
        tgt = tk ? mtgt[i] : mpc + 32'd4;
    endfunction

    function automatic void model_edge();
        bit hit, tk;
        logic [31:0] tgt;
        int i;
        model_predict(hit, tk, tgt);
        if (hit && !bus.stall_i && !bus.redirect_i) mhit++;
        if (bus.redirect_i) mmis++;
        if (bus.upd_valid_i) begin
            i = slot(bus.upd_pc_i);
            if (mv[i] && mtag[i] == tagof(bus.upd_pc_i)) begin
                if (bus.upd_taken_i) begin
                    mcnt[i] = (mcnt[i] + 1 > CMAX) ? CMAX : mcnt[i] + 1;
                    mtgt[i] = bus.upd_target_i;
                end else begin
                    mcnt[i] = (mcnt[i] - 1 < 0) ? 0 : mcnt[i] - 1;
                end
            end else if (bus.upd_taken_i) begin
                mv[i]   = 1'b1;
                mtag[i] = tagof(bus.upd_pc_i);
                mtgt[i] = bus.upd_target_i;
                mcnt[i] = CHALF;
            end
        end
        if (bus.redirect_i)    mpc = bus.redirect_pc_i;
        else if (!bus.stall_i) mpc = tgt;
    endfunction

    task automatic check_model(input string tag);
        bit hit, tk;
        logic [31:0] tgt;
        model_predict(hit, tk, tgt);
        chk({tag, " pc"},      bus.pc_o, mpc);
        chk({tag, " taken"},   32'(bus.pred_taken_o), 32'(tk));
        chk({tag, " target"},  bus.pred_target_o, tgt);
        chk({tag, " hits"},    bus.hit_cnt_o, 32'(mhit));
        chk({tag, " mispred"}, bus.mispred_cnt_o, 32'(mmis));
    endtask

    task automatic drive(input bit st, input bit rd, input logic [31:0] rpc,
                         input bit uv, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utgt);
        bus.stall_i       = st;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.upd_valid_i   = uv;
        bus.upd_pc_i      = upc;
        bus.upd_taken_i   = ut;
        bus.upd_target_i  = utgt;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct {
        bit          st;
        bit          rd;
        logic [31:0] rpc;
        bit          uv;
        logic [31:0] upc;
        bit          ut;
        logic [31:0] utgt;
        logic [31:0] epc;
        bit          etk;
        logic [31:0] etgt;
    } vec_t;

    function automatic vec_t mk(input bit st, input bit rd, input logic [31:0] rpc,
                                input bit uv, input logic [31:0] upc, input bit ut,
                                input logic [31:0] utgt, input logic [31:0] epc,
                                input bit etk, input logic [31:0] etgt);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.uv = uv; v.upc = upc; v.ut = ut;
        v.utgt = utgt; v.epc = epc; v.etk = etk; v.etgt = etgt;
        return v;
    endfunction

    vec_t tbl [NVEC];
    logic [31:0] pool [8];

    initial begin
        // Each row: inputs for one cycle, then the expected pre-edge fetch outputs
        tbl[0]  = mk(0, 0, 0,           0, 0,     0, 0,     32'h0,        0, 32'h4);
        tbl[1]  = mk(0, 0, 0,           0, 0,     0, 0,     32'h4,        0, 32'h8);
        tbl[2]  = mk(0, 0, 0,           0, 0,     0, 0,     32'h8,        0, 32'hC);
        tbl[3]  = mk(0, 0, 0,           1, 32'h40, 1, 32'h100, 32'hC,     0, 32'h10);
        tbl[4]  = mk(0, 1, 32'h40,      0, 0,     0, 0,     32'h10,       0, 32'h14);
        tbl[5]  = mk(0, 0, 0,           0, 0,     0, 0,     32'h40,       1, 32'h100);
        tbl[6]  = mk(0, 0, 0,           1, 32'h40, 0, 0,     32'h100,     0, 32'h104);
        tbl[7]  = mk(0, 1, 32'h40,      1, 32'h40, 0, 0,     32'h104,     0, 32'h108);
        tbl[8]  = mk(0, 0, 0,           1, 32'h40, 1, 32'h100, 32'h40,    0, 32'h44);
        tbl[9]  = mk(0, 1, 32'h40,      1, 32'h40, 1, 32'h100, 32'h44,    0, 32'h48);
        tbl[10] = mk(0, 0, 0,           1, 32'h40, 1, 32'h100, 32'h40,    1, 32'h100);
        tbl[11] = mk(0, 0, 0,           1, 32'h40, 1, 32'h100, 32'h100,   0, 32'h104);
        tbl[12] = mk(0, 1, 32'h40,      1, 32'h40, 1, 32'h100, 32'h104,   0, 32'h108);
        tbl[13] = mk(0, 0, 0,           1, 32'h40, 0, 0,     32'h40,      1, 32'h100);
        tbl[14] = mk(0, 1, 32'h40,      0, 0,     0, 0,     32'h100,      0, 32'h104);
        tbl[15] = mk(1, 1, 32'h40,      1, 32'h80, 1, 32'h300, 32'h40,    1, 32'h100);
        tbl[16] = mk(1, 0, 0,           0, 0,     0, 0,     32'h40,       0, 32'h44);
        tbl[17] = mk(0, 1, 32'h80,      0, 0,     0, 0,     32'h40,       0, 32'h44);
        tbl[18] = mk(0, 1, 32'hFFFFFFFC, 0, 0,    0, 0,     32'h80,       1, 32'h300);
        tbl[19] = mk(0, 0, 0,           0, 0,     0, 0,     32'hFFFFFFFC, 0, 32'h0);
        tbl[20] = mk(0, 0, 0,           0, 0,     0, 0,     32'h0,        0, 32'h4);
        tbl[21] = mk(0, 0, 0,           0, 0,     0, 0,     32'h4,        0, 32'h8);

        pool[0] = 32'h40;  pool[1] = 32'h80;       pool[2] = 32'h44;  pool[3] = 32'h100;
        pool[4] = 32'h3C;  pool[5] = 32'hFFFFFFFC; pool[6] = 32'h200; pool[7] = 32'h1000;

        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset pc", bus.pc_o, 32'h0);
        chk("reset taken", 32'(bus.pred_taken_o), 32'h0);
        chk("reset target", bus.pred_target_o, 32'h4);
        chk("reset hits", bus.hit_cnt_o, 32'h0);
        chk("reset mispred", bus.mispred_cnt_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < int'(NVEC); v++) begin
            drive(tbl[v].st, tbl[v].rd, tbl[v].rpc, tbl[v].uv, tbl[v].upc, tbl[v].ut, tbl[v].utgt);
            #1;
            chk($sformatf("vec%0d pc", v), bus.pc_o, tbl[v].epc);
            chk($sformatf("vec%0d taken", v), 32'(bus.pred_taken_o), 32'(tbl[v].etk));
            chk($sformatf("vec%0d target", v), bus.pred_target_o, tbl[v].etgt);
            check_model($sformatf("vec%0d model", v));
            cycle();
        end

        // Stall and redirect together: redirect wins, only mispredicts count
        begin
            longint hit_before, mis_before;
            hit_before = mhit;
            mis_before = mmis;
            drive(1, 1, 32'h200, 0, 0, 0, 0);
            cycle();
            #1;
            chk("stall+redir pc", bus.pc_o, 32'h200);
            chk("stall+redir mispred", bus.mispred_cnt_o, 32'(mis_before + 1));
            chk("stall+redir hits", bus.hit_cnt_o, 32'(hit_before));
        end

        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 6) == 0, ($urandom % 8) == 0, pool[$urandom % 8],
                  1'($urandom % 2), pool[$urandom % 8], ($urandom % 3) != 0,
                  pool[$urandom % 8]);
            #1;
            check_model($sformatf("rand%0d", n));
            cycle();
        end

        // Async reset mid-run, with a taken update pending across the edge
        drive(0, 0, 0, 1, 32'h40, 1, 32'h500);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst pc", bus.pc_o, 32'h0);
        chk("async rst taken", 32'(bus.pred_taken_o), 32'h0);
        chk("async rst target", bus.pred_target_o, 32'h4);
        chk("async rst hits", bus.hit_cnt_o, 32'h0);
        chk("async rst mispred", bus.mispred_cnt_o, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
        for (int p = 0; p < 8; p++) begin
            drive(0, 1, pool[p], 0, 0, 0, 0);
            cycle();
            #1;
            chk($sformatf("post-rst pc%0d", p), bus.pc_o, pool[p]);
            chk($sformatf("post-rst miss%0d", p), 32'(bus.pred_taken_o), 32'h0);
            chk($sformatf("post-rst tgt%0d", p), bus.pred_target_o, pool[p] + 32'd4);
            check_model($sformatf("post-rst%0d", p));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
